// File: rtl/alu_unit.sv
// Multi-cycle ALU: single-cycle EXEC path for logic/arith ops, optional shift-add multiplier.
// Define ALU_MUL_EN to build the multiplier (op 111); otherwise op 111 yields zero in EXEC.
module alu_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [2:0]       op,
   input  logic             alu_start,
   input  logic             alu_out_en,
   output logic [WIDTH-1:0] bus_out,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic [3:0]       flags
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opA_q, opA_d;
   logic [WIDTH-1:0] opB_q, opB_d;
   logic [2:0]       opCode_q, opCode_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;

   logic [WIDTH-1:0] execRes;
   logic             execC;
   logic             execV;
   logic [WIDTH:0]   addW;
   logic [WIDTH:0]   subW;

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH:0]     mulSum;
`endif

   // Single-cycle datapath on the latched operands; carry of SUB is NOT borrow.
   always_comb begin
      addW    = {1'b0, opA_q} + {1'b0, opB_q};
      subW    = {1'b0, opA_q} - {1'b0, opB_q};
      execRes = '0;
      execC   = 1'b0;
      execV   = 1'b0;
      case (opCode_q)
         3'b000: begin
            execRes = addW[WIDTH-1:0];
            execC   = addW[WIDTH];
            execV   = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) && (execRes[WIDTH-1] != opA_q[WIDTH-1]);
         end
         3'b001: begin
            execRes = subW[WIDTH-1:0];
            execC   = ~subW[WIDTH];
            execV   = (opA_q[WIDTH-1] != opB_q[WIDTH-1]) && (execRes[WIDTH-1] != opA_q[WIDTH-1]);
         end
         3'b010: execRes = opA_q & opB_q;
         3'b011: execRes = opA_q | opB_q;
         3'b100: execRes = opA_q ^ opB_q;
         3'b101: begin
            execRes = {opA_q[WIDTH-2:0], 1'b0};
            execC   = opA_q[WIDTH-1];
         end
         3'b110: begin
            execRes = {1'b0, opA_q[WIDTH-1:1]};
            execC   = opA_q[0];
         end
         default: execRes = '0;
      endcase
   end

`ifdef ALU_MUL_EN
   // Shift-add step: high half accumulates A when the current multiplier bit is set.
   always_comb begin
      mulSum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opA_q} : '0);
   end
`endif

   // Next-state and register updates; result/flags change only on completion.
   always_comb begin
      state_d  = state_q;
      opA_d    = opA_q;
      opB_d    = opB_q;
      opCode_d = opCode_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flags_d  = flags_q;
`ifdef ALU_MUL_EN
      prod_d   = prod_q;
`endif
      case (state_q)
         IDLE: begin
            if (alu_start) begin
               opA_d    = a_in;
               opB_d    = b_in;
               opCode_d = op;
               cnt_d    = '0;
               state_d  = EXEC;
`ifdef ALU_MUL_EN
               if (op == 3'b111) begin
                  state_d = MUL;
                  prod_d  = {{WIDTH{1'b0}}, b_in};
               end
`endif
            end
         end
         EXEC: begin
            result_d = execRes;
            flags_d  = {(execRes == '0), execC, execRes[WIDTH-1], execV};
            state_d  = DONE;
         end
         MUL: begin
`ifdef ALU_MUL_EN
            if (cnt_q == CW'(WIDTH)) begin
               result_d = prod_q[WIDTH-1:0];
               flags_d  = {(prod_q[WIDTH-1:0] == '0), (prod_q[2*WIDTH-1:WIDTH] != '0),
                           prod_q[WIDTH-1], 1'b0};
               state_d  = DONE;
            end else begin
               prod_d = {mulSum, prod_q[WIDTH-1:1]};
               cnt_d  = cnt_q + CW'(1);
            end
`else
            state_d = IDLE;
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         opA_q    <= '0;
         opB_q    <= '0;
         opCode_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
`ifdef ALU_MUL_EN
         prod_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         opA_q    <= opA_d;
         opB_q    <= opB_d;
         opCode_q <= opCode_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
`ifdef ALU_MUL_EN
         prod_q   <= prod_d;
`endif
      end
   end

   assign result  = result_q;
   assign flags   = flags_q;
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign bus_out = alu_out_en ? result_q : '0;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: stimulus pushes expected completions, a monitor pops them on done.
module tb_alu_unit;

   localparam int WIDTH = 16;
   localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
                          OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] a_in, b_in;
   logic [2:0]       op;
   logic             alu_start, alu_out_en;
   logic [WIDTH-1:0] bus_out, result;
   logic             busy, done;
   logic [3:0]       flags;

   alu_unit #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .op(op),
      .alu_start(alu_start), .alu_out_en(alu_out_en), .bus_out(bus_out),
      .result(result), .busy(busy), .done(done), .flags(flags)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string            name;
      logic [WIDTH-1:0] res;
      logic [3:0]       flg;
      int               doneEdge;
   } exp_t;

   exp_t sb[$];
   int nChecks = 0;
   int nFail   = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      nChecks++;
      if (act !== expv) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // Monitor: done is sampled mid-cycle, so the edge that captures it is cyc+1.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               nChecks++;
               nFail++;
               $display("[TB] FAIL unexpectedDone: done high at cycle %0d with nothing outstanding", cyc);
            end else begin
               e = sb.pop_front();
               checkOutput({e.name, ".result"}, 32'(result), 32'(e.res));
               checkOutput({e.name, ".flags"}, 32'(flags), 32'(e.flg));
               checkOutput({e.name, ".doneEdge"}, 32'(cyc + 1), 32'(e.doneEdge));
            end
         end
      end
   end

   // Issue one operation; inputs are scrambled right after latching.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [2:0] opc, input logic [WIDTH-1:0] expRes,
                                input logic [3:0] expFlg, input int lat, input string name);
      @(negedge clk);
      a_in      = a;
      b_in      = b;
      op        = opc;
      alu_start = 1'b1;
      sb.push_back('{name, expRes, expFlg, cyc + 1 + lat});
      @(posedge clk);
      #1;
      alu_start = 1'b0;
      a_in      = ~a;
      b_in      = a ^ 16'h5A5A;
      op        = ~opc;
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (sb.size() != 0 && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         nChecks++;
         nFail++;
         $display("[TB] FAIL %s.timeout: %0d completions still pending, required 0", name, sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      rst        = 1'b1;
      a_in       = '0;
      b_in       = '0;
      op         = '0;
      alu_start  = 1'b0;
      alu_out_en = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset.result", 32'(result), 32'h0);
      checkOutput("reset.flags", 32'(flags), 32'h0);
      checkOutput("reset.busy", 32'(busy), 32'h0);
      checkOutput("reset.done", 32'(done), 32'h0);
      checkOutput("reset.bus_out", 32'(bus_out), 32'h0);
      rst = 1'b0;

      applyStimulus(16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 4'b0011, 2, "addOvf");
      checkOutput("addOvf.busy", 32'(busy), 32'h1);
      drain("addOvf");
      applyStimulus(16'h0005, 16'h0005, OP_SUB, 16'h0000, 4'b1100, 2, "subEq");
      drain("subEq");
      applyStimulus(16'h0003, 16'h0005, OP_SUB, 16'hFFFE, 4'b0010, 2, "subNeg");
      drain("subNeg");
      applyStimulus(16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 4'b1100, 2, "addCarry");
      drain("addCarry");
      applyStimulus(16'hF0F0, 16'h3C3C, OP_AND, 16'h3030, 4'b0000, 2, "and");
      drain("and");
      applyStimulus(16'hF0F0, 16'h0F0F, OP_OR, 16'hFFFF, 4'b0010, 2, "or");
      drain("or");
      applyStimulus(16'hAAAA, 16'hAAAA, OP_XOR, 16'h0000, 4'b1000, 2, "xor");
      drain("xor");
      applyStimulus(16'h0003, 16'h0000, OP_SHR, 16'h0001, 4'b0100, 2, "shrC");
      drain("shrC");
      applyStimulus(16'h8000, 16'h0000, OP_SHR, 16'h4000, 4'b0000, 2, "shrLogical");
      drain("shrLogical");

      applyStimulus(16'h8001, 16'h0000, OP_SHL, 16'h0002, 4'b0100, 2, "shl");
      drain("shl");
      repeat (3) @(negedge clk);
      checkOutput("shl.hold", 32'(result), 32'h0002);
      alu_out_en = 1'b0;
      #1;
      checkOutput("busOut.disabled", 32'(bus_out), 32'h0000);
      alu_out_en = 1'b1;
      #1;
      checkOutput("busOut.enabled", 32'(bus_out), 32'h0002);

      // A start arriving while EXEC is in flight must be dropped.
      applyStimulus(16'h0002, 16'h0003, OP_ADD, 16'h0005, 4'b0000, 2, "busyIgnore");
      @(negedge clk);
      checkOutput("busyIgnore.busy", 32'(busy), 32'h1);
      a_in      = 16'hFFFF;
      b_in      = 16'h0001;
      op        = OP_SUB;
      alu_start = 1'b1;
      @(posedge clk);
      #1;
      alu_start = 1'b0;
      drain("busyIgnore");
      repeat (4) @(negedge clk);

`ifdef ALU_MUL_EN
      applyStimulus(16'h0100, 16'h0100, OP_MUL, 16'h0000, 4'b1100, WIDTH + 2, "mulHigh");
      drain("mulHigh");
      applyStimulus(16'h00FF, 16'h0003, OP_MUL, 16'h02FD, 4'b0000, WIDTH + 2, "mulSmall");
      drain("mulSmall");
      applyStimulus(16'h00FF, 16'h0003, OP_MUL, 16'h02FD, 4'b0000, WIDTH + 2, "mulRestart");
      repeat (5) @(negedge clk);
      a_in      = 16'h1234;
      b_in      = 16'h0010;
      op        = OP_MUL;
      alu_start = 1'b1;
      @(posedge clk);
      #1;
      alu_start = 1'b0;
      drain("mulRestart");
      applyStimulus(16'hFFFF, 16'hFFFF, OP_MUL, 16'h0001, 4'b0100, WIDTH + 2, "mulMax");
      drain("mulMax");
`else
      applyStimulus(16'h1234, 16'h5678, OP_MUL, 16'h0000, 4'b1000, 2, "op111NoMul");
      drain("op111NoMul");
`endif

      applyStimulus(16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 4'b0101, 2, "subOvf");
      drain("subOvf");

      // Abort an operation in flight: no completion is expected for it.
      @(negedge clk);
      a_in      = 16'h00FF;
      b_in      = 16'h0003;
      op        = OP_MUL;
      alu_start = 1'b1;
      @(posedge clk);
      #1;
      alu_start = 1'b0;
`ifdef ALU_MUL_EN
      repeat (8) @(posedge clk);
`endif
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("abort.busy", 32'(busy), 32'h0);
      checkOutput("abort.result", 32'(result), 32'h0);
      checkOutput("abort.flags", 32'(flags), 32'h0);
      checkOutput("abort.done", 32'(done), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (WIDTH + 4) @(negedge clk);
      checkOutput("abort.resultAfter", 32'(result), 32'h0);

      applyStimulus(16'h0001, 16'h0001, OP_ADD, 16'h0002, 4'b0000, 2, "addAfterAbort");
      drain("addAfterAbort");

      $display("[TB] %0d/%0d checks passed", nChecks - nFail, nChecks);
      $finish;
   end

endmodule
